// File: rtl/distortion_source.sv
// Channel-side sample generator: adds optional LFSR noise with saturation to
// clean 8-bit samples and presents a 5-deep history window to the FIR filter.
module distortion_source #(
  parameter int          NOISE_BITS = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_sample,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       noise_en,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] distortedInput,
  output logic [7:0] distortedInputm1,
  output logic [7:0] distortedInputm2,
  output logic [7:0] distortedInputm3,
  output logic [7:0] distortedInputm4
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [2:0]  FULL     = 3'd5;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [7:0]  win_q [5];
  logic [7:0]  win_d [5];
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  fill_q, fill_d;
  logic        vld_q, vld_d;
  logic        accept;
  logic [7:0]  noise;

  assign in_ready = !flush && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign noise    = noise_en ? {{(8-NOISE_BITS){1'b0}}, lfsr_q[NOISE_BITS-1:0]} : 8'h00;

  always_comb begin
    win_d  = win_q;
    lfsr_d = lfsr_q;
    fill_d = fill_q;
    vld_d  = vld_q;
    if (flush) begin
      for (int k = 0; k < 5; k++) win_d[k] = 8'h00;
      fill_d = 3'd0;
      vld_d  = 1'b0;
    end else if (accept) begin
      win_d[4] = win_q[3];
      win_d[3] = win_q[2];
      win_d[2] = win_q[1];
      win_d[1] = win_q[0];
      win_d[0] = sat_add(in_sample, noise);
      lfsr_d   = lfsr_step(lfsr_q);
      fill_d   = (fill_q == FULL) ? FULL : fill_q + 3'd1;
      vld_d    = (fill_d == FULL);
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Registered window / control stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) win_q[k] <= 8'h00;
      lfsr_q <= SEED_EFF;
      fill_q <= 3'd0;
      vld_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 5; k++) win_q[k] <= win_d[k];
      lfsr_q <= lfsr_d;
      fill_q <= fill_d;
      vld_q  <= vld_d;
    end
  end

  assign out_valid        = vld_q;
  assign distortedInput   = win_q[0];
  assign distortedInputm1 = win_q[1];
  assign distortedInputm2 = win_q[2];
  assign distortedInputm3 = win_q[3];
  assign distortedInputm4 = win_q[4];

endmodule

// File: tb/tb_distortion_source.sv
// Self-checking bench for distortion_source: queue-based reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_distortion_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_sample = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       noise_en = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] dw [5];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  distortion_source #(.NOISE_BITS(3), .LFSR_SEED(16'hACE1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_sample        (in_sample),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .noise_en         (noise_en),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .distortedInput   (dw[0]),
    .distortedInputm1 (dw[1]),
    .distortedInputm2 (dw[2]),
    .distortedInputm3 (dw[3]),
    .distortedInputm4 (dw[4])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: history queue of accepted distorted samples, newest first.
  logic [7:0]  hist [$];
  bit          mv;
  logic [15:0] mlfsr;
  int          m_noise, m_sum;

  function automatic logic [7:0] mwin(input int k);
    return (k < hist.size()) ? hist[k] : 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      mv    = 1'b0;
      mlfsr = 16'hACE1;
    end else if (flush) begin
      hist.delete();
      mv = 1'b0;
    end else if (in_valid && (!mv || out_ready)) begin
      m_noise = noise_en ? int'(mlfsr) % 8 : 0;
      m_sum   = int'(in_sample) + m_noise;
      hist.push_front((m_sum > 255) ? 8'd255 : m_sum[7:0]);
      if (hist.size() > 5) void'(hist.pop_back());
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      mv    = (hist.size() == 5);
    end else if (mv && out_ready) begin
      mv = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", in_ready, !flush && (!mv || out_ready));
      chk("model_out_valid", out_valid, mv);
      for (int k = 0; k < 5; k++)
        chk($sformatf("model_win%0d", k), dw[k], mwin(k));
    end
  end

  task automatic cyc(input logic [7:0] s, input logic v, input logic ne,
                     input logic ordy, input logic fl);
    in_sample = s; in_valid = v; noise_en = ne; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic chk_win(input string name, input int a, input int b, input int c,
                         input int d, input int e);
    chk({name, "_w0"}, dw[0], a[15:0]);
    chk({name, "_w1"}, dw[1], b[15:0]);
    chk({name, "_w2"}, dw[2], c[15:0]);
    chk({name, "_w3"}, dw[3], d[15:0]);
    chk({name, "_w4"}, dw[4], e[15:0]);
  endtask

  task automatic prime(input string name);
    for (int i = 0; i < 5; i++) begin
      cyc(8'(10 * (i + 1)), 1'b1, 1'b0, 1'b1, 1'b0);
      chk({name, "_vld"}, out_valid, (i == 4));
    end
    chk_win(name, 50, 40, 30, 20, 10);
    cyc(8'd60, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_win({name, "6"}, 60, 50, 40, 30, 20);
    chk({name, "6_vld"}, out_valid, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_win("reset", 0, 0, 0, 0, 0);
    chk("reset_vld", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Noise and saturation from the reset seed
    cyc(8'd255, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("noise_sat", dw[0], 255);
    cyc(8'd100, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("noise_103", dw[0], 103);
    chk("noise_m1", dw[1], 255);

    // Flush with a sample pending: no accept, everything cleared
    in_sample = 8'd1; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #3 chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk_win("flush", 0, 0, 0, 0, 0);
    chk("flush_vld", out_valid, 0);
    flush = 1'b0;

    prime("prime");

    // Backpressure: three stalled cycles with a sample waiting
    in_sample = 8'd70; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      #3 chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_hold_w0", dw[0], 60);
      chk("bp_hold_vld", out_valid, 1);
    end
    cyc(8'd70, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_win("bp_rel", 70, 60, 50, 40, 30);
    cyc(8'd80, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_win("bp_next", 80, 70, 60, 50, 40);

    // Drain: consume with no new sample
    cyc(8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_vld", out_valid, 0);
    chk("drain_w0", dw[0], 80);
    cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_idle_vld", out_valid, 0);
    cyc(8'd90, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("refill_vld", out_valid, 1);
    chk("refill_w1", dw[1], 80);

    // Flush a primed window, then refill with noise (LFSR continuity via model)
    cyc(8'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_win("flush2", 0, 0, 0, 0, 0);
    chk("flush2_vld", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(8'(200 + i), 1'b1, 1'b1, 1'b1, 1'b0);
      chk("flush2_refill_vld", out_valid, (i == 4));
    end

    // Asynchronous reset between edges while a window is valid
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_win("areset", 0, 0, 0, 0, 0);
    chk("areset_vld", out_valid, 0);
    chk("areset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(8'd255, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("areset_noise_sat", dw[0], 255);
    cyc(8'd100, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("areset_noise_103", dw[0], 103);

    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prime("reprime");

    repeat (3) cyc(8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
